mul_issue_ctrl: RTL and testbench

- Sequencer directly upstream of the exe-stage iterative multiplier; the downstream multiplier is integrated via the multiplier ports below.
- Accepts one MUL/MULH/MULHSU/MULHU/MULW request via valid/ready.
- Holds operands, func3 and int_32 stable for the multiplier's full 3-cycle operation, then captures the result.
- Presents the captured result with its destination tag to writeback via valid/ready; handles pipeline flush.

---
 rtl/mul_issue_ctrl_pkg.sv | 33 +++
 rtl/mul_issue_ctrl_if.sv | 46 ++++
 rtl/mul_issue_ctrl.sv | 115 +++++++++++
 tb/tb_mul_issue_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the multiplier issue sequencer: request/writeback records,
// FSM encoding and the fixed multiplier latency.
package mul_issue_ctrl_pkg;

  typedef logic [63:0] bus64_t;

  localparam int MUL_RD_W  = 5;
  localparam int MUL_TAG_W = 6;
  localparam int MUL_LAT   = 3;

  typedef struct packed {
    logic [2:0]           func3;
    logic                 int_32;
    bus64_t               src1;
    bus64_t               src2;
    logic [MUL_RD_W-1:0]  rd;
    logic [MUL_TAG_W-1:0] tag;
  } mul_req_t;

  typedef struct packed {
    bus64_t               result;
    logic [MUL_RD_W-1:0]  rd;
    logic [MUL_TAG_W-1:0] tag;
  } mul_wb_t;

  typedef enum logic [1:0] {
    MUL_IDLE  = 2'd0,
    MUL_ISSUE = 2'd1,
    MUL_WAIT  = 2'd2,
    MUL_CAPT  = 2'd3
  } mul_fsm_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request, multiplier and writeback signals of the multiplier issue sequencer.
// The slave modport is the sequencer's view, master is the surrounding pipeline.
interface mul_issue_ctrl_if
  import mul_issue_ctrl_pkg::*;
#(
  parameter int RD_W  = 5,
  parameter int TAG_W = 6
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_func3_i;
  logic             req_int_32_i;
  bus64_t           req_src1_i;
  bus64_t           req_src2_i;
  logic [RD_W-1:0]  req_rd_i;
  logic [TAG_W-1:0] req_tag_i;

  logic             mul_request_o;
  logic             mul_kill_o;
  logic [2:0]       mul_func3_o;
  logic             mul_int_32_o;
  bus64_t           mul_src1_o;
  bus64_t           mul_src2_o;
  bus64_t           mul_result_i;
  logic             mul_stall_i;

  logic             wb_valid_o;
  logic             wb_ready_i;
  bus64_t           wb_result_o;
  logic [RD_W-1:0]  wb_rd_o;
  logic [TAG_W-1:0] wb_tag_o;

  modport slave (
    input  req_valid_i, req_func3_i, req_int_32_i, req_src1_i, req_src2_i,
           req_rd_i, req_tag_i, mul_result_i, mul_stall_i, wb_ready_i,
    output req_ready_o, mul_request_o, mul_kill_o, mul_func3_o, mul_int_32_o,
           mul_src1_o, mul_src2_o, wb_valid_o, wb_result_o, wb_rd_o, wb_tag_o
  );

  modport master (
    output req_valid_i, req_func3_i, req_int_32_i, req_src1_i, req_src2_i,
           req_rd_i, req_tag_i, mul_result_i, mul_stall_i, wb_ready_i,
    input  req_ready_o, mul_request_o, mul_kill_o, mul_func3_o, mul_int_32_o,
           mul_src1_o, mul_src2_o, wb_valid_o, wb_result_o, wb_rd_o, wb_tag_o
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sequencer in front of the 3-cycle iterative multiplier: holds one request's
// operands for the whole operation and buffers the result for writeback.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int RD_W  = 5,
  parameter int TAG_W = 6
) (
  input logic             clk_i,
  input logic             rstn_i,
  input logic             flush_i,
  mul_issue_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = MUL_IDLE;
  localparam logic [1:0] S_ISSUE = MUL_ISSUE;
  localparam logic [1:0] S_WAIT  = MUL_WAIT;
  localparam logic [1:0] S_CAPT  = MUL_CAPT;

  logic [1:0]       state;
  logic [2:0]       hold_func3;
  logic             hold_int_32;
  bus64_t           hold_src1;
  bus64_t           hold_src2;
  logic [RD_W-1:0]  hold_rd;
  logic [TAG_W-1:0] hold_tag;

  logic             wb_valid;
  bus64_t           wb_result;
  logic [RD_W-1:0]  wb_rd;
  logic [TAG_W-1:0] wb_tag;

  logic req_ready;
  logic accept;
  logic capt_load;

  // A new op may only start when the output buffer is empty or emptying this
  // cycle, so the capture three cycles later can never clobber a pending result.
  assign req_ready = (state == S_IDLE) & ~flush_i & (~wb_valid | bus.wb_ready_i);
  assign accept    = bus.req_valid_i & req_ready;
  assign capt_load = (state == S_CAPT) & ~flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT:  state <= S_CAPT;
        S_CAPT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Hold registers only change on accept; the multiplier samples func3/int_32
  // again in its done cycle, so they must survive through CAPT.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_func3  <= '0;
      hold_int_32 <= 1'b0;
      hold_src1   <= '0;
      hold_src2   <= '0;
      hold_rd     <= '0;
      hold_tag    <= '0;
    end else if (accept) begin
      hold_func3  <= bus.req_func3_i;
      hold_int_32 <= bus.req_int_32_i;
      hold_src1   <= bus.req_src1_i;
      hold_src2   <= bus.req_src2_i;
      hold_rd     <= bus.req_rd_i;
      hold_tag    <= bus.req_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_valid  <= 1'b0;
      wb_result <= '0;
      wb_rd     <= '0;
      wb_tag    <= '0;
    end else if (flush_i) begin
      wb_valid <= 1'b0;
    end else if (capt_load) begin
      wb_valid  <= 1'b1;
      wb_result <= bus.mul_result_i;
      wb_rd     <= hold_rd;
      wb_tag    <= hold_tag;
    end else if (wb_valid && bus.wb_ready_i) begin
      wb_valid <= 1'b0;
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.mul_request_o = (state == S_ISSUE);
  assign bus.mul_kill_o    = flush_i & (state != S_IDLE);
  assign bus.mul_func3_o   = hold_func3;
  assign bus.mul_int_32_o  = hold_int_32;
  assign bus.mul_src1_o    = hold_src1;
  assign bus.mul_src2_o    = hold_src2;
  assign bus.wb_valid_o    = wb_valid;
  assign bus.wb_result_o   = wb_result;
  assign bus.wb_rd_o       = wb_rd;
  assign bus.wb_tag_o      = wb_tag;

  a_stall_busy: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((state == S_ISSUE) || (state == S_WAIT)) |-> bus.mul_stall_i);

  a_stall_free: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((state == S_IDLE) || (state == S_CAPT)) |-> !bus.mul_stall_i);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed vector table, multi-cycle corner sequences
// and a randomized run against a transaction-level queue model.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl_if #(.RD_W(5), .TAG_W(6)) bus ();

  mul_issue_ctrl #(.RD_W(5), .TAG_W(6)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .flush_i(flush),
    .bus    (bus)
  );

  // RISC-V M-extension product; func3 1xx yields 0 from the multiplier.
  function automatic logic [63:0] ref_mul(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    p  = '0;
    if (f[2]) return 64'd0;
    case (f[1:0])
      2'd0: begin
        p = ua * ub;
        return w ? {{32{p[31]}}, p[31:0]} : p[63:0];
      end
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return p[127:64];
  endfunction

  // Multiplier stand-in: request cycle, one busy cycle, then the done cycle.
  logic mbusy, mdone;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
    end else if (bus.mul_kill_o) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
    end else begin
      mbusy <= bus.mul_request_o;
      mdone <= mbusy;
    end
  end
  assign bus.mul_stall_i  = bus.mul_request_o | mbusy;
  assign bus.mul_result_i = mdone ? ref_mul(bus.mul_func3_o, bus.mul_int_32_o,
                                            bus.mul_src1_o, bus.mul_src2_o) : 64'd0;

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [5:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic [5:0]  tag;
  } exp_t;

  vec_t tbl[9];
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic [5:0] tg);
    bus.req_func3_i  = f;
    bus.req_int_32_i = w;
    bus.req_src1_i   = a;
    bus.req_src2_i   = b;
    bus.req_rd_i     = rd;
    bus.req_tag_i    = tg;
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] f, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] rd, input logic [5:0] tg);
    int n;
    n = 0;
    set_req(f, w, a, b, rd, tg);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) chk("send_timeout", bus.req_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    send(v.f, v.w, v.a, v.b, v.rd, v.tag);
    @(negedge clk);
    chk({nm, "_issue_req"}, bus.mul_request_o, 1'b1);
    chk({nm, "_hold_src1"}, bus.mul_src1_o, v.a);
    chk({nm, "_hold_src2"}, bus.mul_src2_o, v.b);
    @(negedge clk);
    chk({nm, "_wait_req"}, bus.mul_request_o, 1'b0);
    chk({nm, "_wait_wbv"}, bus.wb_valid_o, 1'b0);
    @(negedge clk);
    chk({nm, "_capt_wbv"}, bus.wb_valid_o, 1'b0);
    chk({nm, "_capt_func3"}, bus.mul_func3_o, v.f);
    chk({nm, "_capt_int32"}, bus.mul_int_32_o, v.w);
    @(negedge clk);
    chk({nm, "_wbv"}, bus.wb_valid_o, 1'b1);
    chk({nm, "_res"}, bus.wb_result_o, v.exp);
    chk({nm, "_rd"}, bus.wb_rd_o, v.rd);
    chk({nm, "_tag"}, bus.wb_tag_o, v.tag);
    bus.wb_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom % 5)
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [2:0]  rf;
    logic        rw;
    logic        inflt;
    int          age;
    exp_t        e;

    bus.req_valid_i = 1'b0;
    bus.wb_ready_i  = 1'b0;
    set_req(3'd0, 1'b0, 64'd0, 64'd0, 5'd0, 6'd0);

    tbl[0] = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 6'd10, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[1] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd2, 6'd11, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2] = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 6'd12,
               64'hFFFF_FFFF_FFFF_FFFE};
    tbl[3] = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 6'd13, 64'd0};
    tbl[4] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 6'd14,
               64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{3'd1, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd6, 6'd15, 64'd1};
    tbl[6] = '{3'd0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_FFFF_FFFF, 5'd7, 6'd16, 64'd1};
    tbl[7] = '{3'd5, 1'b0, 64'd7, 64'd9, 5'd8, 6'd17, 64'd0};
    tbl[8] = '{3'd0, 1'b0, 64'h1234, 64'h10, 5'd31, 6'd63, 64'h12340};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", bus.wb_valid_o, 1'b0);
    chk("rst_wb_result", bus.wb_result_o, 64'd0);
    chk("rst_wb_rd", bus.wb_rd_o, 5'd0);
    chk("rst_wb_tag", bus.wb_tag_o, 6'd0);
    chk("rst_mul_request", bus.mul_request_o, 1'b0);
    chk("rst_mul_kill", bus.mul_kill_o, 1'b0);
    chk("rst_hold_src1", bus.mul_src1_o, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready_o, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back with writeback stalled
    send(3'd0, 1'b0, 64'd6, 64'd7, 5'd3, 6'd9);
    repeat (4) @(negedge clk);
    chk("b2b_a_wbv", bus.wb_valid_o, 1'b1);
    chk("b2b_a_res", bus.wb_result_o, 64'd42);
    @(posedge clk); #1;
    set_req(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd4, 6'd20);
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b2b_blocked_ready", bus.req_ready_o, 1'b0);
      chk("b2b_stable_res", bus.wb_result_o, 64'd42);
      chk("b2b_stable_tag", bus.wb_tag_o, 6'd9);
      @(posedge clk); #1;
    end
    bus.wb_ready_i = 1'b1;
    @(negedge clk);
    chk("b2b_drain_ready", bus.req_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.wb_ready_i  = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_a_drained", bus.wb_valid_o, 1'b0);
    chk("b2b_b_issue", bus.mul_request_o, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b_b_wbv", bus.wb_valid_o, 1'b1);
    chk("b2b_b_res", bus.wb_result_o, 64'd2);
    chk("b2b_b_tag", bus.wb_tag_o, 6'd20);
    bus.wb_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0;

    // Flush in WAIT
    send(3'd0, 1'b0, 64'd5, 64'd5, 5'd9, 6'd30);
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_kill", bus.mul_kill_o, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_wait_idle", bus.req_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("flush_wait_no_wb", bus.wb_valid_o, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    run_vec('{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 6'd31, 64'd0},
            "after_flush");

    // Flush with a stalled result and a coincident request
    send(3'd0, 1'b0, 64'd11, 64'd3, 5'd11, 6'd32);
    repeat (4) @(negedge clk);
    chk("fbuf_wbv", bus.wb_valid_o, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    set_req(3'd0, 1'b0, 64'd1, 64'd1, 5'd12, 6'd33);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    chk("fbuf_no_accept", bus.req_ready_o, 1'b0);
    chk("fbuf_idle_no_kill", bus.mul_kill_o, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk("fbuf_wbv_drop", bus.wb_valid_o, 1'b0);
    chk("fbuf_not_issued", bus.mul_request_o, 1'b0);
    @(posedge clk); #1;

    // Async reset during ISSUE
    send(3'd0, 1'b0, 64'd100, 64'd100, 5'd13, 6'd34);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_request", bus.mul_request_o, 1'b0);
    chk("arst_kill", bus.mul_kill_o, 1'b0);
    chk("arst_wbv", bus.wb_valid_o, 1'b0);
    chk("arst_src1", bus.mul_src1_o, 64'd0);
    chk("arst_rd", bus.wb_rd_o, 5'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    run_vec('{3'd0, 1'b0, 64'd100, 64'd100, 5'd13, 6'd34, 64'd10000}, "after_rst");

    // Randomized traffic against a queue model: one result buffer, one op in
    // flight, result visible four cycles after the accept cycle.
    inflt = 1'b0;
    age   = 0;
    for (int i = 0; i < 800; i++) begin
      rf = 3'($urandom % 8);
      if (rf > 3'd4) rf = 3'($urandom % 4);
      rw = (rf == 3'd0) && ($urandom % 2 == 0);
      set_req(rf, rw, rnd64(), rnd64(), 5'($urandom), 6'($urandom));
      bus.req_valid_i = ($urandom % 3) != 0;
      flush           = ($urandom % 40) == 0;
      bus.wb_ready_i  = flush ? 1'b0 : (($urandom % 3) != 0);
      @(negedge clk);
      if (inflt) begin
        age++;
        if (age == 4) inflt = 1'b0;
      end
      chk("rnd_wb_valid", bus.wb_valid_o, (q.size() == 1) && !inflt);
      if (bus.wb_valid_o && q.size() > 0) begin
        chk("rnd_res", bus.wb_result_o, q[0].res);
        chk("rnd_rd", bus.wb_rd_o, q[0].rd);
        chk("rnd_tag", bus.wb_tag_o, q[0].tag);
      end
      if (flush || inflt)
        chk("rnd_ready_blocked", bus.req_ready_o, 1'b0);
      else if (q.size() == 0 || bus.wb_ready_i)
        chk("rnd_ready_free", bus.req_ready_o, 1'b1);
      if (bus.wb_valid_o && bus.wb_ready_i && q.size() > 0) void'(q.pop_front());
      if (flush) begin
        q.delete();
        inflt = 1'b0;
      end else if (bus.req_valid_i && bus.req_ready_o) begin
        e.res = ref_mul(bus.req_func3_i, bus.req_int_32_i, bus.req_src1_i, bus.req_src2_i);
        e.rd  = bus.req_rd_i;
        e.tag = bus.req_tag_i;
        q.push_back(e);
        inflt = 1'b1;
        age   = 0;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.wb_ready_i  = 1'b1;
    repeat (6) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
